// File: rtl/jk_cmd_seq.sv
// Command sequencer feeding a JK flip-flop: queues {op, cnt} commands, replays
// each op on jk for cnt cycles and tracks the flip-flop's expected q.
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic [1:0]       jk,
    output logic             busy,
    output logic             done,
    output logic             q_model
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {ST_IDLE, ST_DRIVE} state_t;

    logic [CNT_W+1:0] mem_q [DEPTH];
    logic [CNT_W+1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [1:0]       jk_q, jk_d;
    logic             q_model_q, q_model_d;

    logic             full, empty, push, pop;
    logic [CNT_W+1:0] head;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    always_comb begin
        full      = (occ_q == OCC_FULL);
        empty     = (occ_q == '0);
        cmd_ready = !full && !rst;
        push      = cmd_valid && cmd_ready;
        head      = mem_q[rd_ptr_q];
        head_op   = head[CNT_W+1:CNT_W];
        head_cnt  = head[CNT_W-1:0];
        // The head is consumed whenever nothing is being driven or the current
        // command is on its last cycle, which gives back-to-back replay.
        pop       = !empty && ((state_q == ST_IDLE) || (rem_q == '0));

        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = {cmd_op, cmd_cnt};
        end
        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        occ_d = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        state_d = state_q;
        rem_d   = rem_q;
        jk_d    = jk_q;
        if ((state_q == ST_DRIVE) && (rem_q != '0)) begin
            rem_d = rem_q - CNT_ONE;
        end else if (pop && (head_cnt != '0)) begin
            state_d = ST_DRIVE;
            jk_d    = head_op;
            rem_d   = head_cnt - CNT_ONE;
        end else begin
            // Finished with nothing queued, or a zero-count entry discarded.
            state_d = ST_IDLE;
            jk_d    = 2'b00;
        end

        case (jk_q)
            2'b01:   q_model_d = 1'b0;
            2'b10:   q_model_d = 1'b1;
            2'b11:   q_model_d = ~q_model_q;
            default: q_model_d = q_model_q;
        endcase

        done    = (state_q == ST_DRIVE) && (rem_q == '0);
        busy    = (state_q == ST_DRIVE) || !empty;
        jk      = jk_q;
        q_model = q_model_q;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            jk_q      <= 2'b00;
            q_model_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            state_q   <= state_d;
            rem_q     <= rem_d;
            jk_q      <= jk_d;
            q_model_q <= q_model_d;
        end
    end
endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed vector table, full-FIFO and reset-abort
// sequences, then random traffic against a schedule-based reference model.
module tb_jk_cmd_seq;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int TL    = 16384;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = 2'b00;
    logic [3:0] cmd_cnt   = 4'd0;
    logic       cmd_ready;
    logic [1:0] jk;
    logic       busy, done, q_model;
    logic       ff_q   = 1'b0;
    logic       ff_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .jk        (jk),
        .busy      (busy),
        .done      (done),
        .q_model   (q_model)
    );

    // The real flip-flop; only cleared by the bench, never by the sequencer.
    always @(posedge clk) begin
        if (ff_clr) ff_q <= 1'b0;
        else begin
            case (jk)
                2'b01:   ff_q <= 1'b0;
                2'b10:   ff_q <= 1'b1;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted command is scheduled on a timeline of
    // post-edge jk values. Pop edge = max(accept edge + 1, time the previous
    // command releases the driver); a zero count occupies one 00 cycle.
    logic [1:0] exp_jk   [TL];
    bit         exp_drv  [TL];
    bit         exp_done [TL];
    int         t, t_free;
    int         pend[$];
    logic       q_m;

    function automatic logic apply_jk(input logic q, input logic [1:0] c);
        case (c)
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            2'b11:   return ~q;
            default: return q;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TL; i++) begin
            exp_jk[i]   = 2'b00;
            exp_drv[i]  = 1'b0;
            exp_done[i] = 1'b0;
        end
        t = 0;
        t_free = 0;
        pend.delete();
        q_m = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        ff_clr = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ff_clr = 1'b0;
        model_reset();
    endtask

    task automatic run_cycle(input logic v, input logic [1:0] op, input logic [3:0] c,
                             input bit chk_ff, output bit acc, output logic rdy_seen);
        bit exp_rdy;
        bit exp_busy;
        int p;
        cmd_valid = v;
        cmd_op = op;
        cmd_cnt = c;
        #1;
        exp_rdy = (pend.size() < DEPTH);
        rdy_seen = cmd_ready;
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) begin
            p = (t + 1 > t_free) ? t + 1 : t_free;
            if (p + 16 >= TL) begin
                $display("FAIL timeline: index %0d beyond model range", p);
                $fatal(1, "timeline overflow");
            end
            if (c != 4'd0) begin
                for (int i = 0; i < int'(c); i++) begin
                    exp_jk[p+i]  = op;
                    exp_drv[p+i] = 1'b1;
                end
                exp_done[p+int'(c)-1] = 1'b1;
                t_free = p + int'(c);
            end else begin
                t_free = p + 1;
            end
            pend.push_back(p);
        end
        @(posedge clk);
        #1;
        q_m = apply_jk(q_m, (t == 0) ? 2'b00 : exp_jk[t-1]);
        while (pend.size() > 0 && pend[0] <= t) void'(pend.pop_front());
        exp_busy = exp_drv[t] || (pend.size() > 0);
        chk("jk", 32'(jk), 32'(exp_jk[t]));
        chk("done", 32'(done), 32'(exp_done[t]));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("q_model", 32'(q_model), 32'(q_m));
        if (chk_ff) chk("ff_q_vs_q_model", 32'(ff_q), 32'(q_model));
        t++;
    endtask

    typedef struct {
        logic       rst;
        logic       vld;
        logic [1:0] op;
        logic [3:0] cnt;
        logic       rdy;
        logic [1:0] jk;
        logic       done;
        logic       busy;
        logic       q;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input logic r, input logic v, input logic [1:0] op, input logic [3:0] c,
                           input logic rdy, input logic [1:0] ejk, input logic d,
                           input logic b, input logic q);
        vec_t e;
        e.rst = r; e.vld = v; e.op = op; e.cnt = c;
        e.rdy = rdy; e.jk = ejk; e.done = d; e.busy = b; e.q = q;
        tbl.push_back(e);
    endtask

    logic [1:0] sb[$];
    logic [1:0] prev_jk;
    logic       prev_done;

    task automatic check_start();
        if (jk != 2'b00 && (prev_jk == 2'b00 || prev_done)) begin
            if (sb.size() == 0) chk("order_extra_cmd", 32'(jk), 32'(0));
            else chk("order_op", 32'(jk), 32'(sb.pop_front()));
        end
        prev_jk = jk;
        prev_done = done;
    endtask

    initial begin
        bit         acc;
        logic       rdy;
        int         sel, acc_before, pushes, k;
        bit         seen_low;
        logic [1:0] ops [3];
        logic [1:0] rop;
        logic [3:0] rcnt;
        logic       rv;

        // rst vld op cnt | rdy jk done busy q  (ready before the edge, rest after)
        add_vec(1'b1, 1'b0, 2'b00, 4'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 2'b10, 4'd2, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b1, 1'b1, 2'b11, 4'd5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 2'b11, 4'd3, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 2'b01, 4'd1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b1, 2'b10, 4'd0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b1, 2'b11, 4'd1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 2'b00, 4'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            cmd_valid = tbl[i].vld;
            cmd_op = tbl[i].op;
            cmd_cnt = tbl[i].cnt;
            #1;
            chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(tbl[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_jk", i), 32'(jk), 32'(tbl[i].jk));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_q", i), 32'(q_model), 32'(tbl[i].q));
        end

        // Full FIFO: valid held high with maximum counts.
        do_reset();
        ops[0] = 2'b01; ops[1] = 2'b10; ops[2] = 2'b11;
        sel = 0; acc_before = 0; seen_low = 1'b0;
        prev_jk = 2'b00; prev_done = 1'b0;
        sb.delete();
        for (int i = 0; i < 70; i++) begin
            run_cycle(1'b1, ops[sel], 4'd15, 1'b0, acc, rdy);
            if (!seen_low) begin
                if (rdy) acc_before++;
                else seen_low = 1'b1;
            end
            if (acc) begin
                sb.push_back(ops[sel]);
                sel = (sel + 1) % 3;
            end
            check_start();
        end
        chk("full_accepts_before_drop", 32'(acc_before), 32'(DEPTH + 1));
        k = 0;
        while ((pend.size() > 0 || t <= t_free) && k < 300) begin
            run_cycle(1'b0, 2'b00, 4'd0, 1'b0, acc, rdy);
            check_start();
            k++;
        end
        if (k >= 300) chk("full_drain_budget", 32'(k), 32'(0));
        chk("order_left_in_scoreboard", 32'(sb.size()), 32'(0));

        // Reset in the 4th drive cycle of a long toggle with two queued behind it.
        do_reset();
        run_cycle(1'b1, 2'b11, 4'd8, 1'b0, acc, rdy);
        run_cycle(1'b1, 2'b10, 4'd3, 1'b0, acc, rdy);
        run_cycle(1'b1, 2'b01, 4'd2, 1'b0, acc, rdy);
        run_cycle(1'b0, 2'b00, 4'd0, 1'b0, acc, rdy);
        run_cycle(1'b0, 2'b00, 4'd0, 1'b0, acc, rdy);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b10;
        cmd_cnt = 4'd5;
        #1;
        chk("abort_ready_in_rst", 32'(cmd_ready), 32'(0));
        @(posedge clk);
        #1;
        chk("abort_jk", 32'(jk), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_q_model", 32'(q_model), 32'(0));
        chk("abort_ready_rst_held", 32'(cmd_ready), 32'(0));
        rst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("abort_ready_after_rst", 32'(cmd_ready), 32'(1));
        model_reset();
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 2'b00, 4'd0, 1'b0, acc, rdy);

        // Random traffic with the flip-flop tracked against q_model.
        do_reset();
        pushes = 0;
        k = 0;
        while (pushes < 500 && k < 8000) begin
            rv   = 1'($urandom_range(0, 1));
            rop  = 2'($urandom_range(0, 3));
            rcnt = 4'($urandom_range(0, 15));
            run_cycle(rv, rop, rcnt, 1'b1, acc, rdy);
            if (acc) pushes++;
            k++;
        end
        chk("rand_pushes_within_budget", 32'(pushes), 32'(500));
        k = 0;
        while ((pend.size() > 0 || t <= t_free) && k < 300) begin
            run_cycle(1'b0, 2'b00, 4'd0, 1'b1, acc, rdy);
            k++;
        end
        if (k >= 300) chk("rand_drain_budget", 32'(k), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jk_cmd_seq.md
Name: jk_cmd_seq

Overview:
Command sequencer that sits directly upstream of the JK flip-flop and drives its 2-bit jk input. It accepts queued operations (hold, reset, set, toggle), each with a repeat count, over a valid/ready handshake. It buffers them in a small FIFO and replays each as a registered jk code for exactly cnt clock cycles. It also maintains a cycle-exact model of the flip-flop's q for checking and for downstream use.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 4, width of the repeat count field

Ports:
clk  input  1  rising-edge clock, shared with the JK flip-flop
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept a command
cmd_op  input  2  jk code: 00 hold, 01 reset, 10 set, 11 toggle
cmd_cnt  input  CNT_W  number of cycles to drive cmd_op
jk  output  2  registered code to the flip-flop's jk input
busy  output  1  FIFO non-empty or a command is being driven
done  output  1  high during the last drive cycle of a command
q_model  output  1  predicted flip-flop q

Behaviour:
- Reset (rst high at a rising clk edge): FIFO emptied, state IDLE, rem=0, jk=00, q_model=0, done=0, busy=0.
- cmd_ready is forced to 0 while rst is high. Commands are ignored during reset.
- Handshake:
  - Push occurs on an edge where cmd_valid && cmd_ready. cmd_ready = !full && !rst.
  - No push when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle when not full leave the occupancy unchanged.
  - The FIFO uses wrap-around read/write pointers plus an occupancy counter 0..DEPTH.
- State IDLE:
  - jk=00.
  - On an edge with the FIFO non-empty, pop the head.
  - If the head's cnt>0: jk<=op, rem<=cnt-1, go to DRIVE.
  - If the head's cnt==0: discard it, stay IDLE with jk=00. A discard costs one cycle.
- State DRIVE:
  - jk holds op. done = (state==DRIVE && rem==0).
  - rem>0: rem<=rem-1.
  - rem==0, FIFO non-empty, head cnt>0: pop and load back-to-back (jk<=new op, rem<=cnt-1). There is no 00 gap.
  - rem==0, FIFO non-empty, head cnt==0: pop and discard, jk<=00, go to IDLE.
  - rem==0, FIFO empty: jk<=00, go to IDLE.
- Latency: a command pushed at edge E0 into an empty, idle block is popped at E1. jk shows op from E1 through E1+cnt, and the flip-flop samples it at E2..E1+cnt.
- Maximum cnt of 2^CNT_W-1 must drive exactly that many cycles, with no wrap of rem.
- busy = (state==DRIVE) || (occupancy!=0).
- q_model update at every non-reset edge, using the current jk output (the same value the flip-flop samples):
  - 00: unchanged
  - 01: 0
  - 10: 1
  - 11: inverted
- Reset mid-command aborts immediately: jk=00 from the next cycle and queued commands are lost. The flip-flop itself is not reset, so q_model and the real q may diverge. This is a bench check item, not a block concern.

Test Plan:
- Single set: after reset, push op=10 cnt=2 at E0 -> jk=10 for exactly 2 cycles from E1, then 00. done high only in the second jk=10 cycle. q_model goes 0->1 at E2. busy deasserts after E3.
- Back-to-back toggle: push op=11 cnt=3 then op=01 cnt=1 on consecutive edges -> jk=11 for 3 cycles then 01 for 1 cycle with no 00 gap. q_model sequence 1,0,1 then 0. Two done pulses.
- Zero count: push op=10 cnt=0, then op=11 cnt=1 -> first entry discarded in one cycle with jk staying 00. Then jk=11 for 1 cycle; q_model 0->1.
- Full FIFO: hold cmd_valid with cnt=15 entries -> cmd_ready drops after DEPTH+1 accepts (DEPTH queued plus 1 popped). It reasserts exactly one cycle after a pop. No command is lost or duplicated; check with a scoreboard of op order.
- Reset mid-operation: push op=11 cnt=8 plus 2 more commands, assert rst at the 4th drive cycle -> next cycle jk=00, busy=0, q_model=0, cmd_ready=0 while rst is high and 1 after. The queued commands are never driven.
- Random: 500 random pushes (random op, cnt 0..15, random cmd_valid) with the flip-flop instantiated and never reset mid-run -> the flip-flop's q equals q_model on every cycle.
